// File: rtl/clause_operand_builder.sv
// rtl/clause_operand_builder.sv - fetches a clause record and its literals' variable states into evaluator operand vectors
// Optional early-out on a satisfied literal: define SAT_SHORTCUT_EN.
module clause_operand_builder #(
  parameter int VAR_PER_CLAUSE = 5,
  parameter int VAR_IDX_W      = 8,
  parameter int CLAUSE_IDX_W   = 9
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic                                      req_valid,
  output logic                                      req_ready,
  input  logic [CLAUSE_IDX_W-1:0]                   req_clause_idx,
  output logic                                      cmem_rd_en,
  output logic [CLAUSE_IDX_W-1:0]                   cmem_addr,
  input  logic [VAR_PER_CLAUSE*(VAR_IDX_W+2)-1:0]   cmem_rd_data,
  output logic                                      vt_rd_en,
  output logic [VAR_IDX_W-1:0]                      vt_addr,
  input  logic                                      vt_rd_unassign,
  input  logic                                      vt_rd_val,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [CLAUSE_IDX_W-1:0]                   out_clause_idx,
  output logic [VAR_PER_CLAUSE-1:0]                 unassign,
  output logic [VAR_PER_CLAUSE-1:0]                 clause_mask,
  output logic [VAR_PER_CLAUSE-1:0]                 val,
  output logic [VAR_PER_CLAUSE-1:0]                 clause_pole
);

  localparam int SLOT_BITS = VAR_IDX_W + 2;
  localparam int SLOT_W    = (VAR_PER_CLAUSE > 1) ? $clog2(VAR_PER_CLAUSE) : 1;

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] CLAUSE_RD  = 3'd1;
  localparam logic [2:0] CLAUSE_CAP = 3'd2;
  localparam logic [2:0] VAR_RD     = 3'd3;
  localparam logic [2:0] DRAIN      = 3'd4;
  localparam logic [2:0] OUT        = 3'd5;

  logic [2:0]                state;
  logic [CLAUSE_IDX_W-1:0]   idx_q;
  logic [VAR_IDX_W-1:0]      var_idx_q [VAR_PER_CLAUSE];
  logic [VAR_PER_CLAUSE-1:0] rem_q;
  logic                      rsp_valid;
  logic [SLOT_W-1:0]         rsp_slot;

  logic [VAR_IDX_W-1:0]      cap_var [VAR_PER_CLAUSE];
  logic [VAR_PER_CLAUSE-1:0] cap_pole;
  logic [VAR_PER_CLAUSE-1:0] cap_mask;
  logic [VAR_PER_CLAUSE-1:0] issue_oh;
  logic [VAR_PER_CLAUSE-1:0] rem_next;
  logic [SLOT_W-1:0]         issue_slot;
  logic                      sat_hit;

  function automatic logic [SLOT_W-1:0] lowest_slot(input logic [VAR_PER_CLAUSE-1:0] m);
    logic [SLOT_W-1:0] r;
    r = '0;
    for (int i = VAR_PER_CLAUSE - 1; i >= 0; i--) begin
      if (m[i]) r = SLOT_W'(i);
    end
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < VAR_PER_CLAUSE; i++) begin
      cap_var[i]  = cmem_rd_data[i*SLOT_BITS +: VAR_IDX_W];
      cap_pole[i] = cmem_rd_data[i*SLOT_BITS + VAR_IDX_W];
      cap_mask[i] = cmem_rd_data[i*SLOT_BITS + VAR_IDX_W + 1];
    end
  end

  // rem_q holds the active slots not yet issued; the lowest one goes next.
  assign issue_oh   = rem_q & (~rem_q + 1'b1);
  assign rem_next   = rem_q & ~issue_oh;
  assign issue_slot = lowest_slot(rem_q);

`ifdef SAT_SHORTCUT_EN
  assign sat_hit = rsp_valid && !vt_rd_unassign && (vt_rd_val == clause_pole[rsp_slot]);
`else
  assign sat_hit = 1'b0;
`endif

  assign req_ready      = (state == IDLE);
  assign cmem_rd_en     = (state == CLAUSE_RD);
  assign cmem_addr      = (state == CLAUSE_RD) ? idx_q : '0;
  assign vt_rd_en       = (state == VAR_RD);
  assign vt_addr        = (state == VAR_RD) ? var_idx_q[issue_slot] : '0;
  assign out_valid      = (state == OUT);
  assign out_clause_idx = idx_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      idx_q       <= '0;
      rem_q       <= '0;
      rsp_valid   <= 1'b0;
      rsp_slot    <= '0;
      unassign    <= '0;
      val         <= '0;
      clause_mask <= '0;
      clause_pole <= '0;
      for (int i = 0; i < VAR_PER_CLAUSE; i++) var_idx_q[i] <= '0;
    end else begin
      // A response arriving while still reading or draining belongs to rsp_slot.
      if (rsp_valid && (state == VAR_RD || state == DRAIN)) begin
        unassign[rsp_slot] <= vt_rd_unassign;
        val[rsp_slot]      <= vt_rd_val & ~vt_rd_unassign;
      end
      case (state)
        IDLE: begin
          if (req_valid) begin
            idx_q <= req_clause_idx;
            state <= CLAUSE_RD;
          end
        end
        CLAUSE_RD: state <= CLAUSE_CAP;
        CLAUSE_CAP: begin
          for (int i = 0; i < VAR_PER_CLAUSE; i++) var_idx_q[i] <= cap_var[i];
          clause_mask <= cap_mask;
          clause_pole <= cap_pole & cap_mask;
`ifdef SAT_SHORTCUT_EN
          // Slots skipped by an early exit must read as unassigned.
          unassign    <= cap_mask;
`else
          unassign    <= '0;
`endif
          val         <= '0;
          rem_q       <= cap_mask;
          rsp_valid   <= 1'b0;
          state       <= (cap_mask == '0) ? OUT : VAR_RD;
        end
        VAR_RD: begin
          rsp_valid <= 1'b1;
          rsp_slot  <= issue_slot;
          rem_q     <= rem_next;
          if (sat_hit) begin
            rsp_valid <= 1'b0;
            state     <= OUT;
          end else if (rem_next == '0) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          rsp_valid <= 1'b0;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clause_operand_builder.sv
// tb/tb_clause_operand_builder.sv - randomized self-checking bench for clause_operand_builder
module tb_clause_operand_builder;

  localparam int N  = 5;
  localparam int VW = 8;
  localparam int CW = 9;
  localparam int SB = VW + 2;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [CW-1:0]     req_clause_idx = '0;
  logic              cmem_rd_en;
  logic [CW-1:0]     cmem_addr;
  logic [N*SB-1:0]   cmem_rd_data = '0;
  logic              vt_rd_en;
  logic [VW-1:0]     vt_addr;
  logic              vt_rd_unassign = 1'b0;
  logic              vt_rd_val = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [CW-1:0]     out_clause_idx;
  logic [N-1:0]      unassign, clause_mask, val, clause_pole;

  logic [N*SB-1:0]   cmem [512];
  logic              vt_un [256];
  logic              vt_v  [256];

  int total = 0;
  int bad   = 0;

  clause_operand_builder #(.VAR_PER_CLAUSE(N), .VAR_IDX_W(VW), .CLAUSE_IDX_W(CW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_clause_idx(req_clause_idx),
    .cmem_rd_en(cmem_rd_en), .cmem_addr(cmem_addr), .cmem_rd_data(cmem_rd_data),
    .vt_rd_en(vt_rd_en), .vt_addr(vt_addr),
    .vt_rd_unassign(vt_rd_unassign), .vt_rd_val(vt_rd_val),
    .out_valid(out_valid), .out_ready(out_ready), .out_clause_idx(out_clause_idx),
    .unassign(unassign), .clause_mask(clause_mask), .val(val), .clause_pole(clause_pole)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (cmem_rd_en) cmem_rd_data <= cmem[cmem_addr];
    if (vt_rd_en) begin
      vt_rd_unassign <= vt_un[vt_addr];
      vt_rd_val      <= vt_v[vt_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_clause(input int c, input logic [N-1:0] mask, input logic [N-1:0] pole,
                            input logic [N*VW-1:0] vars);
    logic [N*SB-1:0] w;
    w = '0;
    for (int i = 0; i < N; i++) begin
      w[i*SB +: VW]   = vars[i*VW +: VW];
      w[i*SB + VW]     = pole[i];
      w[i*SB + VW + 1] = mask[i];
    end
    cmem[c] = w;
  endtask

  task automatic run_req(input int c, input int hold);
    logic [N*SB-1:0] w;
    logic [N-1:0]    em, ep, eu, ev;
    int              addrs[$];
    int              m, lat, npulse, var_i;
    bit              sat;
    logic [29:0]     exp_out;

    w = cmem[c];
    em = '0; ep = '0; eu = '0; ev = '0; m = 0; sat = 0;
    for (int i = 0; i < N; i++) begin
      if (w[i*SB + VW + 1]) begin
        var_i = int'(w[i*SB +: VW]);
        em[i] = 1'b1;
        ep[i] = w[i*SB + VW];
        m++;
        addrs.push_back(var_i);
        if (sat) begin
          eu[i] = 1'b1;
        end else begin
          eu[i] = vt_un[var_i];
          ev[i] = vt_v[var_i] & ~vt_un[var_i];
`ifdef SAT_SHORTCUT_EN
          if (!vt_un[var_i] && vt_v[var_i] == ep[i]) sat = 1;
`endif
        end
      end
    end

    @(negedge clock);
    req_valid = 1'b1;
    req_clause_idx = CW'(c);
    check("req_ready_idle", req_ready, 1);
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    check("req_ready_busy", req_ready, 0);
    lat = 1; npulse = 0;
    while (!out_valid && lat < 60) begin
      if (vt_rd_en) begin
        if (npulse < addrs.size()) check("vt_addr", vt_addr, addrs[npulse]);
        else check("vt_extra_pulse", npulse, addrs.size());
        npulse++;
      end
      @(negedge clock);
      lat++;
    end
    if (!out_valid) begin
      check("out_valid_timeout", 0, 1);
      return;
    end
`ifndef SAT_SHORTCUT_EN
    check("latency", lat, (m == 0) ? 3 : m + 4);
    check("vt_pulses", npulse, m);
`endif
    check("clause_mask", clause_mask, em);
    check("clause_pole", clause_pole, ep);
    check("unassign", unassign, eu);
    check("val", val, ev);
    check("out_clause_idx", out_clause_idx, c);
    exp_out = {1'b1, eu, ev, ep, em, CW'(c)};
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      check("hold_stable", {out_valid, unassign, val, clause_pole, clause_mask, out_clause_idx}, exp_out);
    end
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    out_ready = 1'b0;
    check("out_valid_drop", out_valid, 0);
    check("req_ready_after", req_ready, 1);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) cmem[i] = '0;
    for (int v = 0; v < 256; v++) begin
      vt_un[v] = 1'b0;
      vt_v[v]  = 1'b0;
    end

    repeat (3) @(negedge clock);
    check("rst_out_valid", out_valid, 0);
    check("rst_vt_rd_en", vt_rd_en, 0);
    check("rst_cmem_rd_en", cmem_rd_en, 0);
    reset = 1'b1;
    @(negedge clock);
    check("rst_req_ready", req_ready, 1);
    check("rst_vectors", {unassign, val, clause_pole, clause_mask}, 0);

    // Full build
    set_clause(3, 5'b11111, 5'b00111, {8'd5, 8'd4, 8'd3, 8'd2, 8'd1});
    vt_un[3] = 1'b1;
    vt_v[1] = 1'b1; vt_v[2] = 1'b1; vt_v[4] = 1'b0; vt_v[5] = 1'b0;
    run_req(3, 0);

    // Sparse mask
    set_clause(4, 5'b10100, 5'b10100, {8'd9, 8'd0, 8'd7, 8'd0, 8'd0});
    vt_un[7] = 1'b0; vt_v[7] = 1'b0; vt_un[9] = 1'b0; vt_v[9] = 1'b0;
    run_req(4, 1);

    // Empty clause
    set_clause(5, 5'b00000, 5'b11111, {8'd1, 8'd2, 8'd3, 8'd4, 8'd5});
    run_req(5, 0);

    // Backpressure
    run_req(3, 10);

    // Satisfied first literal
    set_clause(6, 5'b11111, 5'b11110, {8'd24, 8'd23, 8'd22, 8'd21, 8'd20});
    vt_un[20] = 1'b0; vt_v[20] = 1'b0;
    run_req(6, 2);

    // Reset during VAR_RD, then a fresh build
    @(negedge clock);
    req_valid = 1'b1; req_clause_idx = CW'(3);
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    for (int k = 0; k < 10 && !vt_rd_en; k++) @(negedge clock);
    check("reached_var_rd", vt_rd_en, 1);
    reset = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_vt_rd_en", vt_rd_en, 0);
    check("midrst_unassign", unassign, 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_req_ready", req_ready, 1);
    check("midrst_out_idle", out_valid, 0);
    run_req(3, 0);

    // Random clauses and variable tables
    for (int t = 0; t < 40; t++) begin
      int c;
      logic [N*VW-1:0] vars;
      c = int'($urandom_range(0, 511));
      for (int i = 0; i < N; i++) vars[i*VW +: VW] = VW'($urandom_range(0, 255));
      set_clause(c, N'($urandom), N'($urandom), vars);
      for (int v = 0; v < 256; v++) begin
        vt_un[v] = 1'($urandom);
        vt_v[v]  = 1'($urandom);
      end
      run_req(c, int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
